// File: rtl/i2c_slave_axis.sv
// rtl/i2c_slave_axis.sv - I2C write-only target that packs received bytes into AXI-Stream words
//
// Purpose:
//   Responds to I2C write transactions addressed to SLAVE_ADDR. Received bytes
//   are packed MSB-first into DATA_WIDTH words and presented on an AXI-Stream
//   master port. A word that completes while the output register is still
//   occupied is dropped, NACKed on its last byte and flagged on ovf_o.
//
// Ports:
//   clk_i          system clock, at least 8x the SCL frequency
//   arstn_i        asynchronous active-low reset (released synchronously inside)
//   i2c_scl_i      I2C clock from the master
//   i2c_sda_io     I2C data, open-drain (driven 0 or released)
//   m_axis_tdata   assembled word, first received byte in the MSBs
//   m_axis_tvalid  word available
//   m_axis_tready  downstream accept
//   busy_o         high from a matching address ACK until the next STOP
//   ovf_o          one-cycle pulse when a completed word is dropped
`timescale 1ns/1ps
module i2c_slave_axis #(
  parameter int         DATA_WIDTH     = 16,
  parameter int         I2C_DATA_WIDTH = 8,
  parameter logic [6:0] SLAVE_ADDR     = 7'h21
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  i2c_scl_i,
  inout  wire                   i2c_sda_io,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  busy_o,
  output logic                  ovf_o
);

  localparam int BW    = I2C_DATA_WIDTH;
  localparam int BYTES = DATA_WIDTH / BW;
  localparam int CW    = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    IGNORE
  } state_t;

  state_t                state, state_n;
  logic   [1:0]          rst_sync;
  logic                  rst_n;
  logic   [2:0]          scl_sr;
  logic   [2:0]          sda_sr;
  logic                  scl_rise, scl_fall;
  logic                  start_det, stop_det;
  logic                  sda_s;
  logic   [3:0]          bit_cnt;
  logic   [BW-1:0]       byte_sr;
  logic   [CW-1:0]       byte_cnt;
  logic   [DATA_WIDTH-1:0] word_sr;
  logic   [DATA_WIDTH-1:0] word_next;
  logic                  bit_done;
  logic                  word_last;
  logic                  can_load;
  logic                  sda_oe, sda_oe_n;
  logic                  busy_n;

  // Reset asserts asynchronously (so SDA is released at once) but releases
  // synchronously to clk_i.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n = rst_sync[1];

  // [0],[1] form the synchronizer, [2] holds the previous synchronized value
  // for edge detection. Reset to the idle-high bus level so no false edges.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      scl_sr <= 3'b111;
      sda_sr <= 3'b111;
    end else begin
      scl_sr <= {scl_sr[1:0], i2c_scl_i};
      sda_sr <= {sda_sr[1:0], i2c_sda_io};
    end
  end

  assign sda_s     = sda_sr[1];
  assign scl_rise  =  scl_sr[1] & ~scl_sr[2];
  assign scl_fall  = ~scl_sr[1] &  scl_sr[2];
  assign start_det =  sda_sr[2] & ~sda_sr[1] & scl_sr[1] & scl_sr[2];
  assign stop_det  = ~sda_sr[2] &  sda_sr[1] & scl_sr[1] & scl_sr[2];

  assign i2c_sda_io = sda_oe ? 1'b0 : 1'bz;

  assign bit_done  = scl_fall && (bit_cnt == 4'(BW));
  assign word_last = (byte_cnt == CW'(BYTES - 1));
  assign can_load  = !m_axis_tvalid || m_axis_tready;
  assign word_next = (word_sr << BW) | DATA_WIDTH'(byte_sr);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sda_oe <= 1'b0;
      busy_o <= 1'b0;
    end else begin
      state  <= state_n;
      sda_oe <= sda_oe_n;
      busy_o <= busy_n;
    end
  end

  always_comb begin
    state_n  = state;
    sda_oe_n = sda_oe;
    busy_n   = busy_o;
    if (stop_det) begin
      state_n  = IDLE;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else if (start_det) begin
      state_n  = ADDR;
      sda_oe_n = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          sda_oe_n = 1'b0;
        end
        ADDR: begin
          if (bit_done) begin
            if (byte_sr[7:1] == SLAVE_ADDR && !byte_sr[0]) begin
              state_n  = ADDR_ACK;
              sda_oe_n = 1'b1;
            end else begin
              state_n  = IGNORE;
              sda_oe_n = 1'b0;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            state_n  = DATA;
            sda_oe_n = 1'b0;
            busy_n   = 1'b1;
          end
        end
        DATA: begin
          if (bit_done) begin
            state_n  = DATA_ACK;
            // NACK only the last byte of a word that has nowhere to go.
            sda_oe_n = !(word_last && !can_load);
          end
        end
        DATA_ACK: begin
          if (scl_fall) begin
            state_n  = DATA;
            sda_oe_n = 1'b0;
          end
        end
        IGNORE: begin
          sda_oe_n = 1'b0;
        end
        default: begin
          state_n  = IDLE;
          sda_oe_n = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt       <= 4'd0;
      byte_sr       <= '0;
      byte_cnt      <= '0;
      word_sr       <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      ovf_o         <= 1'b0;
    end else begin
      ovf_o <= 1'b0;
      // A load later in this block overrides this clear.
      if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      if (start_det || stop_det) begin
        bit_cnt  <= 4'd0;
        byte_cnt <= '0;
        word_sr  <= '0;
      end else if (state == ADDR || state == DATA) begin
        if (scl_rise && bit_cnt < 4'(BW)) begin
          byte_sr <= {byte_sr[BW-2:0], sda_s};
          bit_cnt <= bit_cnt + 4'd1;
        end else if (bit_done) begin
          bit_cnt <= 4'd0;
          if (state == DATA) begin
            if (word_last) begin
              byte_cnt <= '0;
              word_sr  <= '0;
              if (can_load) begin
                m_axis_tdata  <= word_next;
                m_axis_tvalid <= 1'b1;
              end else begin
                ovf_o <= 1'b1;
              end
            end else begin
              byte_cnt <= byte_cnt + CW'(1);
              word_sr  <= word_next;
            end
          end
        end
      end else begin
        bit_cnt <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_axis.sv
// tb/tb_i2c_slave_axis.sv - scoreboard bench for i2c_slave_axis
`timescale 1ns/1ps
module tb_i2c_slave_axis;

  localparam int Q = 100;

  logic        clk = 1'b0;
  logic        arstn;
  logic        scl;
  logic        m_sda_oe;
  logic        tready;
  wire         sda;
  logic [15:0] tdata;
  logic        tvalid;
  logic        busy;
  logic        ovf;

  int          total = 0;
  int          bad = 0;
  int          ovf_cnt = 0;
  int          ovf_base;
  logic [15:0] exp_q[$];
  logic [15:0] exp_w;

  always #5 clk = ~clk;

  pullup (sda);
  assign sda = m_sda_oe ? 1'b0 : 1'bz;

  i2c_slave_axis #(
    .DATA_WIDTH(16),
    .I2C_DATA_WIDTH(8),
    .SLAVE_ADDR(7'h21)
  ) dut (
    .clk_i(clk),
    .arstn_i(arstn),
    .i2c_scl_i(scl),
    .i2c_sda_io(sda),
    .m_axis_tdata(tdata),
    .m_axis_tvalid(tvalid),
    .m_axis_tready(tready),
    .busy_o(busy),
    .ovf_o(ovf)
  );

  always @(negedge clk) begin
    if (ovf) ovf_cnt++;
    if (tvalid && tready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL beat_unexpected got=%h exp=none", tdata);
      end else begin
        exp_w = exp_q.pop_front();
        if (tdata !== exp_w) begin
          bad++;
          $display("FAIL beat_data got=%h exp=%h", tdata, exp_w);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1;
    tready = v;
  endtask

  task automatic bus_start();
    m_sda_oe = 1'b0; #Q;
    scl = 1'b1;      #Q;
    m_sda_oe = 1'b1; #Q;
    scl = 1'b0;      #Q;
  endtask

  task automatic bus_stop();
    m_sda_oe = 1'b1; #Q;
    scl = 1'b1;      #Q;
    m_sda_oe = 1'b0; #Q;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      m_sda_oe = ~b[i]; #Q;
      scl = 1'b1;       #(2 * Q);
      scl = 1'b0;       #Q;
    end
  endtask

  task automatic send_byte(input string name, input logic [7:0] b, input logic exp_ack);
    logic ack;
    send_bits(b, 8);
    m_sda_oe = 1'b0; #Q;
    scl = 1'b1;      #Q;
    ack = (sda === 1'b0);
    #Q;
    scl = 1'b0;      #Q;
    chk(name, 32'(ack), 32'(exp_ack));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    arstn = 1'b0; scl = 1'b1; m_sda_oe = 1'b0; tready = 1'b1;
    #Q;
    chk("rst_tvalid", 32'(tvalid), 0);
    chk("rst_tdata", 32'(tdata), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_sda", 32'(sda), 1);
    arstn = 1'b1;
    #Q;

    // basic write, tready high
    exp_q.push_back(16'h1234);
    bus_start();
    chk("t1_busy_before_addr", 32'(busy), 0);
    send_byte("t1_addr_ack", 8'h42, 1'b1);
    chk("t1_busy_after_addr", 32'(busy), 1);
    send_byte("t1_b0_ack", 8'h12, 1'b1);
    send_byte("t1_b1_ack", 8'h34, 1'b1);
    chk("t1_busy_before_stop", 32'(busy), 1);
    bus_stop();
    chk("t1_busy_after_stop", 32'(busy), 0);
    chk("t1_beats_left", 32'(exp_q.size()), 0);

    // address mismatch
    bus_start();
    send_byte("t2_addr_nack", 8'h44, 1'b0);
    send_byte("t2_d0_nack", 8'hAA, 1'b0);
    send_byte("t2_d1_nack", 8'hBB, 1'b0);
    chk("t2_busy", 32'(busy), 0);
    bus_stop();

    // read request is ignored
    bus_start();
    send_byte("t3_addr_nack", 8'h43, 1'b0);
    send_byte("t3_ignore_nack", 8'h12, 1'b0);
    chk("t3_busy", 32'(busy), 0);
    bus_stop();

    // backpressure
    set_ready(1'b0);
    bus_start();
    send_byte("t4_addr_ack", 8'h42, 1'b1);
    send_byte("t4_b0_ack", 8'h12, 1'b1);
    send_byte("t4_b1_ack", 8'h34, 1'b1);
    chk("t4_tvalid_held", 32'(tvalid), 1);
    chk("t4_tdata_held", 32'(tdata), 32'h1234);
    ovf_base = ovf_cnt;
    send_byte("t4_b2_ack", 8'h56, 1'b1);
    send_byte("t4_b3_nack", 8'h78, 1'b0);
    bus_stop();
    chk("t4_ovf_pulses", 32'(ovf_cnt - ovf_base), 1);
    chk("t4_tdata_after_drop", 32'(tdata), 32'h1234);
    chk("t4_tvalid_after_drop", 32'(tvalid), 1);
    exp_q.push_back(16'h1234);
    set_ready(1'b1);
    repeat (5) @(posedge clk);
    #1;
    chk("t4_tvalid_drained", 32'(tvalid), 0);
    chk("t4_beats_left", 32'(exp_q.size()), 0);

    // partial word discarded by repeated START
    exp_q.push_back(16'hCDEF);
    bus_start();
    send_byte("t5_addr_ack", 8'h42, 1'b1);
    send_byte("t5_b0_ack", 8'hAB, 1'b1);
    bus_start();
    chk("t5_busy_rstart", 32'(busy), 1);
    send_byte("t5_addr2_ack", 8'h42, 1'b1);
    send_byte("t5_b1_ack", 8'hCD, 1'b1);
    send_byte("t5_b2_ack", 8'hEF, 1'b1);
    bus_stop();
    chk("t5_beats_left", 32'(exp_q.size()), 0);

    // reset while the target is driving the address ACK
    bus_start();
    send_bits(8'h42, 8);
    m_sda_oe = 1'b0; #Q;
    chk("t7_ack_driven", 32'(sda), 0);
    arstn = 1'b0;
    #1;
    chk("t7_sda_released", 32'(sda), 1);
    #Q;
    scl = 1'b1;
    #Q;
    arstn = 1'b1;
    #Q;

    // reset during the 5th bit of a data byte
    bus_start();
    send_byte("t6_addr_ack", 8'h42, 1'b1);
    send_bits(8'hFF, 4);
    m_sda_oe = 1'b0; #Q;
    scl = 1'b1;      #Q;
    arstn = 1'b0;
    #1;
    chk("t6_sda_released", 32'(sda), 1);
    chk("t6_busy_cleared", 32'(busy), 0);
    chk("t6_tvalid_cleared", 32'(tvalid), 0);
    #Q;
    arstn = 1'b1;
    #Q;
    exp_q.push_back(16'h0102);
    bus_start();
    send_byte("t6_addr2_ack", 8'h42, 1'b1);
    send_byte("t6_b0_ack", 8'h01, 1'b1);
    send_byte("t6_b1_ack", 8'h02, 1'b1);
    bus_stop();
    chk("t6_beats_left", 32'(exp_q.size()), 0);

    #Q;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
